// File: rtl/acorn_ad_stream.sv
// acorn_ad_stream -- ACORN-128 associated-data absorber.
//
// Streams an arbitrary-length AD bit string (length a multiple of UNROLL)
// through a valid/ready word port, applying UNROLL StateUpdate128 steps per
// cycle. It then appends the 256-bit padding phase: bit 1 followed by 255
// zeros, with ca=1 for pad bits 0..127 and cb=1 throughout.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           one-cycle pulse; loads state_in / ad_len (ignored while busy)
//   state_in        293-bit state from key/IV initialisation
//   ad_len          AD length in bits
//   ad_valid/ready  AD word handshake; ad_data bit 0 is absorbed first
//   busy            high while absorbing AD or padding
//   done            one-cycle pulse; state_out is final
//   state_out       working state register
//
// Optional build macro ACORN_AD_MSB_FIRST_EN: absorb each AD word starting at
// ad_data[W-1]. For a partial last word the top rem bits are used.
module acorn_ad_stream #(
  parameter int W      = 32,
  parameter int UNROLL = 1,
  parameter int LEN_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [292:0]     state_in,
  input  logic [LEN_W-1:0] ad_len,
  input  logic             ad_valid,
  input  logic [W-1:0]     ad_data,
  output logic             ad_ready,
  output logic             busy,
  output logic             done,
  output logic [292:0]     state_out
);
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {S_IDLE, S_AD, S_PAD} fsm_e;

  fsm_e             fsm_q, fsm_d;
  logic [292:0]     st_q, st_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [W-1:0]     buf_q, buf_d;
  logic [CW-1:0]    cnt_q, cnt_d;   // unconsumed bits left in buf_q
  logic [8:0]       pad_q, pad_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [292:0]     s;
  logic             have_bits, last_chunk;

  function automatic logic maj(input logic x, input logic y, input logic z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic logic ch(input logic x, input logic y, input logic z);
    return (x & y) ^ (~x & z);
  endfunction

  // One StateUpdate128 step. The LFSR feedbacks run top-down so each uses
  // the not-yet-updated lower taps.
  function automatic logic [292:0] upd(input logic [292:0] si, input logic m,
                                       input logic ca, input logic cb);
    logic [292:0] t;
    logic         ks, f;
    t = si;
    t[289] = t[289] ^ t[235] ^ t[230];
    t[230] = t[230] ^ t[196] ^ t[193];
    t[193] = t[193] ^ t[160] ^ t[154];
    t[154] = t[154] ^ t[111] ^ t[107];
    t[107] = t[107] ^ t[66]  ^ t[61];
    t[61]  = t[61]  ^ t[23]  ^ t[0];
    ks = t[12] ^ t[154] ^ maj(t[235], t[61], t[193]) ^ ch(t[230], t[111], t[66]);
    f  = t[0] ^ ~t[107] ^ maj(t[244], t[23], t[160]) ^ (ca & t[196]) ^ (cb & ks);
    return {f ^ m, t[292:1]};
  endfunction

  assign have_bits  = (cnt_q != '0);
  assign last_chunk = (cnt_q == CW'(UNROLL));
  // Refill as the last chunk drains, but only if more AD remains than is
  // already buffered; garbage above a partial last word is never requested.
  assign ad_ready   = (fsm_q == S_AD) && (!have_bits || last_chunk) &&
                      (32'(rem_q) > 32'(cnt_q));

  always_comb begin
    fsm_d  = fsm_q;
    st_d   = st_q;
    rem_d  = rem_q;
    buf_d  = buf_q;
    cnt_d  = cnt_q;
    pad_d  = pad_q;
    busy_d = busy_q;
    done_d = 1'b0;
    s      = st_q;
    case (fsm_q)
      S_IDLE: begin
        if (start) begin
          st_d   = state_in;
          rem_d  = ad_len;
          busy_d = 1'b1;
          cnt_d  = '0;
          pad_d  = '0;
          fsm_d  = (ad_len != '0) ? S_AD : S_PAD;
        end
      end
      S_AD: begin
        if (have_bits) begin
          for (int i = 0; i < UNROLL; i++) begin
`ifdef ACORN_AD_MSB_FIRST_EN
            s = upd(s, buf_q[W-1-i], 1'b1, 1'b1);
`else
            s = upd(s, buf_q[i], 1'b1, 1'b1);
`endif
          end
          st_d  = s;
`ifdef ACORN_AD_MSB_FIRST_EN
          buf_d = buf_q << UNROLL;
`else
          buf_d = buf_q >> UNROLL;
`endif
          cnt_d = cnt_q - CW'(UNROLL);
          rem_d = rem_q - LEN_W'(UNROLL);
          if (rem_d == '0) begin
            fsm_d = S_PAD;
            pad_d = '0;
            cnt_d = '0;   // drop any unused bits of a partial last word
          end
        end
        if (ad_valid && ad_ready) begin
          buf_d = ad_data;
          cnt_d = CW'(W);
        end
      end
      S_PAD: begin
        for (int i = 0; i < UNROLL; i++)
          s = upd(s, (pad_q == 9'd0) && (i == 0), (32'(pad_q) + i) < 128, 1'b1);
        st_d  = s;
        pad_d = pad_q + 9'(UNROLL);
        if (pad_d == 9'd256) begin
          fsm_d  = S_IDLE;
          busy_d = 1'b0;
          done_d = 1'b1;
        end
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q  <= S_IDLE;
      st_q   <= '0;
      rem_q  <= '0;
      buf_q  <= '0;
      cnt_q  <= '0;
      pad_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      fsm_q  <= fsm_d;
      st_q   <= st_d;
      rem_q  <= rem_d;
      buf_q  <= buf_d;
      cnt_q  <= cnt_d;
      pad_q  <= pad_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign state_out = st_q;
endmodule

// File: tb/tb_acorn_ad_stream.sv
// Bench for acorn_ad_stream: one UNROLL=1 and one UNROLL=8 instance (W=32),
// random states/AD checked against a bit-serial ACORN-128 model.
module tb_acorn_ad_stream;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         start_v[2];
  logic [292:0] sin_v[2];
  logic [15:0]  len_v[2];
  logic         val_v[2];
  logic [31:0]  dat_v[2];
  logic         rdy_v[2], busy_v[2], done_v[2];
  logic [292:0] sout_v[2];

  acorn_ad_stream #(.W(32), .UNROLL(1), .LEN_W(16)) u1 (
    .clk(clk), .rst(rst), .start(start_v[0]), .state_in(sin_v[0]), .ad_len(len_v[0]),
    .ad_valid(val_v[0]), .ad_data(dat_v[0]), .ad_ready(rdy_v[0]), .busy(busy_v[0]),
    .done(done_v[0]), .state_out(sout_v[0]));
  acorn_ad_stream #(.W(32), .UNROLL(8), .LEN_W(16)) u8 (
    .clk(clk), .rst(rst), .start(start_v[1]), .state_in(sin_v[1]), .ad_len(len_v[1]),
    .ad_valid(val_v[1]), .ad_data(dat_v[1]), .ad_ready(rdy_v[1]), .busy(busy_v[1]),
    .done(done_v[1]), .state_out(sout_v[1]));

  int           vecs = 0;
  int           errs = 0;
  logic [31:0]  wq[$];          // AD words for the current run
  int           hs_q[$];        // cycles in which a handshake occurred
  int           trk_err;
  logic [292:0] pre[0:128];     // model state before AD bit i

  // ---------------- reference model (bit-serial, straight from the rules) ----
  function automatic logic [292:0] step(input logic [292:0] si, input bit m,
                                        input bit ca, input bit cb);
    logic [292:0] t;
    bit ks, f, mj1, mj2, chv;
    t = si;
    t[289] ^= t[235] ^ t[230];
    t[230] ^= t[196] ^ t[193];
    t[193] ^= t[160] ^ t[154];
    t[154] ^= t[111] ^ t[107];
    t[107] ^= t[66] ^ t[61];
    t[61]  ^= t[23] ^ t[0];
    mj1 = (t[235] + t[61] + t[193]) >= 2;
    chv = t[230] ? t[111] : t[66];
    ks  = t[12] ^ t[154] ^ mj1 ^ chv;
    mj2 = (t[244] + t[23] + t[160]) >= 2;
    f   = t[0] ^ !t[107] ^ mj2 ^ (ca & t[196]) ^ (cb & ks);
    for (int j = 0; j < 292; j++) t[j] = t[j+1];
    t[292] = f ^ m;
    return t;
  endfunction

  function automatic logic [292:0] model(input logic [292:0] sin, input int len);
    logic [292:0] s;
    logic [31:0]  w;
    s = sin;
    for (int i = 0; i < len; i++) begin
      if (i <= 128) pre[i] = s;
      w = wq[i/32];
      s = step(s, w[i%32], 1'b1, 1'b1);
    end
    if (len <= 128) pre[len] = s;
    for (int p = 0; p < 256; p++) s = step(s, p == 0, p < 128, 1'b1);
    return s;
  endfunction

  function automatic logic [292:0] rnd293();
    logic [292:0] r;
    r = '0;
    for (int i = 0; i < 10; i++) r = {r[260:0], 32'($urandom)};
    return r;
  endfunction

  // ---------------- driver: start at edge 0, cycle n follows edge n ---------
  task automatic run(input int d, input logic [292:0] sin, input int len,
                     input int gapmax, input bit spam, input bit track,
                     output int done_cyc);
    int widx, gapc, avail, k;
    hs_q.delete();
    trk_err  = 0;
    done_cyc = -1;
    @(negedge clk);
    start_v[d] = 1'b1; sin_v[d] = sin; len_v[d] = 16'(len);
    @(negedge clk);
    start_v[d] = 1'b0;
    widx = 0; gapc = 0; avail = 0; k = 0;
    for (int cyc = 1; cyc < 3000; cyc++) begin
      if (done_v[d]) begin done_cyc = cyc; break; end
      if (track && k < len && sout_v[d] !== pre[k]) trk_err++;
      if (avail > 0) begin avail--; k++; end
      if (gapc > 0) begin
        val_v[d] = 1'b0; gapc--;
      end else begin
        val_v[d] = 1'b1;
        dat_v[d] = (widx < wq.size()) ? wq[widx] : $urandom;
      end
      if (spam) begin
        start_v[d] = busy_v[d] && ($urandom_range(0, 2) == 0);
        sin_v[d]   = rnd293();
        len_v[d]   = 16'($urandom_range(1, 50) * 8);
      end
      if (val_v[d] && rdy_v[d]) begin
        hs_q.push_back(cyc);
        widx++;
        avail += 32;
        if (gapmax > 0) gapc = $urandom_range(0, gapmax);
      end
      @(negedge clk);
    end
    val_v[d] = 1'b0;
    start_v[d] = 1'b0;
  endtask

  task automatic fill_words(input int n);
    wq.delete();
    for (int i = 0; i < n; i++) wq.push_back($urandom);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      vecs++;
      if (sout_v[d] !== '0) begin
        errs++; $display("FAIL reset_state dut%0d got %h want 0", d, sout_v[d]);
      end
      vecs++;
      if ({busy_v[d], done_v[d], rdy_v[d]} !== 3'b000) begin
        errs++; $display("FAIL reset_flags dut%0d got %b want 000", d,
                         {busy_v[d], done_v[d], rdy_v[d]});
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_l128();
    logic [292:0] sin, exp;
    int dc;
    sin = rnd293();
    fill_words(4);
    exp = model(sin, 128);
    run(0, sin, 128, 0, 1'b0, 1'b1, dc);
    vecs++;
    if (hs_q.size() != 4) begin
      errs++; $display("FAIL l128_hs_count got %0d want 4", hs_q.size());
    end
    for (int i = 0; i < 4 && i < hs_q.size(); i++) begin
      vecs++;
      if (hs_q[i] != 1 + 32*i) begin
        errs++; $display("FAIL l128_hs_cycle[%0d] got %0d want %0d", i, hs_q[i], 1 + 32*i);
      end
    end
    vecs++;
    if (dc != 386) begin errs++; $display("FAIL l128_done_cycle got %0d want 386", dc); end
    vecs++;
    if (sout_v[0] !== exp) begin
      errs++; $display("FAIL l128_state got %h want %h", sout_v[0], exp);
    end
    vecs++;
    if (trk_err != 0) begin errs++; $display("FAIL l128_track got %0d want 0", trk_err); end
    repeat (3) @(negedge clk);
    vecs++;
    if (sout_v[0] !== exp || busy_v[0] !== 1'b0) begin
      errs++; $display("FAIL l128_hold got %h busy %b want %h busy 0", sout_v[0], busy_v[0], exp);
    end
  endtask

  task automatic test_l0();
    logic [292:0] sin, exp;
    int dc;
    for (int d = 0; d < 2; d++) begin
      sin = rnd293();
      wq.delete();
      exp = model(sin, 0);
      run(d, sin, 0, 0, 1'b0, 1'b0, dc);
      vecs++;
      if (hs_q.size() != 0) begin
        errs++; $display("FAIL l0_no_ready dut%0d got %0d handshakes want 0", d, hs_q.size());
      end
      vecs++;
      if (dc != (d == 0 ? 257 : 33)) begin
        errs++; $display("FAIL l0_done_cycle dut%0d got %0d want %0d", d, dc, d == 0 ? 257 : 33);
      end
      vecs++;
      if (sout_v[d] !== exp) begin
        errs++; $display("FAIL l0_state dut%0d got %h want %h", d, sout_v[d], exp);
      end
    end
  endtask

  task automatic test_partial();
    logic [292:0] sin, exp;
    int dc;
    sin = rnd293();
    wq.delete();
    wq.push_back($urandom);
    wq.push_back(32'hFFFF_FF00 | 32'($urandom_range(0, 255)));
    exp = model(sin, 40);
    run(1, sin, 40, 0, 1'b0, 1'b0, dc);
    vecs++;
    if (hs_q.size() != 2 || hs_q[0] != 1 || hs_q[1] != 5) begin
      errs++; $display("FAIL partial_hs got %0d handshakes want 2 at cycles 1,5", hs_q.size());
    end
    vecs++;
    if (dc != 39) begin errs++; $display("FAIL partial_done_cycle got %0d want 39", dc); end
    vecs++;
    if (sout_v[1] !== exp) begin
      errs++; $display("FAIL partial_state got %h want %h", sout_v[1], exp);
    end
  endtask

  task automatic test_gaps();
    logic [292:0] sin, exp, ref0;
    int dc;
    sin = rnd293();
    fill_words(3);
    exp = model(sin, 96);
    run(0, sin, 96, 0, 1'b0, 1'b0, dc);
    ref0 = sout_v[0];
    run(0, sin, 96, 5, 1'b0, 1'b1, dc);
    vecs++;
    if (sout_v[0] !== ref0 || sout_v[0] !== exp) begin
      errs++; $display("FAIL gaps_state got %h want %h", sout_v[0], exp);
    end
    vecs++;
    if (trk_err != 0) begin errs++; $display("FAIL gaps_frozen got %0d bad cycles want 0", trk_err); end
    vecs++;
    if (dc < 2 + 96 + 256) begin errs++; $display("FAIL gaps_done_cycle got %0d want >= 354", dc); end
  endtask

  task automatic test_reset_mid();
    logic [292:0] sin, exp;
    int dc;
    fill_words(4);
    @(negedge clk);
    start_v[0] = 1'b1; sin_v[0] = rnd293(); len_v[0] = 16'd128;
    @(negedge clk);
    start_v[0] = 1'b0;
    for (int cyc = 1; cyc < 20; cyc++) begin
      val_v[0] = 1'b1; dat_v[0] = $urandom;
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    vecs++;
    if (sout_v[0] !== '0 || {busy_v[0], done_v[0], rdy_v[0]} !== 3'b000) begin
      errs++; $display("FAIL midrst_outputs state %h flags %b want 0 000", sout_v[0],
                       {busy_v[0], done_v[0], rdy_v[0]});
    end
    rst = 1'b0; val_v[0] = 1'b0;
    sin = rnd293();
    fill_words(2);
    exp = model(sin, 64);
    run(0, sin, 64, 0, 1'b0, 1'b0, dc);
    vecs++;
    if (sout_v[0] !== exp || dc != 2 + 64 + 256) begin
      errs++; $display("FAIL midrst_rerun got %h cyc %0d want %h cyc 322", sout_v[0], dc, exp);
    end
  endtask

  task automatic test_start_busy();
    logic [292:0] sin, exp;
    int dc;
    sin = rnd293();
    fill_words(2);
    exp = model(sin, 64);
    run(1, sin, 64, 0, 1'b1, 1'b0, dc);
    vecs++;
    if (sout_v[1] !== exp || dc != 2 + 8 + 32) begin
      errs++; $display("FAIL start_busy got %h cyc %0d want %h cyc 42", sout_v[1], dc, exp);
    end
    repeat (2) @(negedge clk);
    vecs++;
    if (busy_v[1] !== 1'b0 || sout_v[1] !== exp) begin
      errs++; $display("FAIL start_busy_idle busy %b state %h want 0 %h", busy_v[1], sout_v[1], exp);
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      start_v[d] = 1'b0; sin_v[d] = '0; len_v[d] = '0; val_v[d] = 1'b0; dat_v[d] = '0;
    end
    test_reset();
    test_l128();
    test_l0();
    test_partial();
    test_gaps();
    test_reset_mid();
    test_start_busy();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
